// File: rtl/fixed_pkg.sv
// Shared constants and types for the sign-magnitude Q15.16 multiplier.
//   WIDTH        operand width (bit WIDTH-1 is the sign)
//   FRAC         fractional bits per operand
//   ACC_W        shift-add accumulator width (31x31 magnitude product)
//   RES_W        registered result width ({2'b0, acc})
//   ROUND_CONST  half-LSB of the selector window, used for round-half-up
//   SEL_HI       top of the selector window result[SEL_HI:FRAC]
//   INT_LO       lowest integer bit of the product (2*FRAC)
//   OVF_LO       first bit above the selector window
package fixed_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned FRAC   = 16;
  localparam int unsigned ACC_W  = 62;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned SEL_HI = FRAC + 30;
  localparam int unsigned INT_LO = 2 * FRAC;
  localparam int unsigned OVF_LO = SEL_HI + 1;
  localparam int unsigned INT_W  = 16;
  localparam int unsigned CNT_W  = 5;

  localparam logic [RES_W-1:0] ROUND_CONST = RES_W'(1) << (FRAC - 1);
  localparam logic [CNT_W-1:0] CNT_INIT    = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

endpackage

// File: rtl/mul_flag_gen.sv
// Combinational post-processing of the multiplier accumulator.
// Optional feature macro: MUL_ROUND_EN (round-half-up on the magnitude).
// Ports:
//   acc_i             magnitude accumulator from the shift-add datapath
//   sign_i            raw product sign (XOR of operand signs)
//   result_o          {2'b0, acc}, rounded when MUL_ROUND_EN is defined
//   signed_result_o   signed integer part of result_o (two's complement)
//   sign_o            sign_i, forced to 0 when result_o is zero
//   overflow_high_o   any bit above the selector window set (pre-round)
//   overflow_shift_o  rounding carried the product above the window
module mul_flag_gen
  import fixed_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic             sign_i,
  output logic [RES_W-1:0] result_o,
  output logic [INT_W-1:0] signed_result_o,
  output logic             sign_o,
  output logic             overflow_high_o,
  output logic             overflow_shift_o
);

  logic [RES_W-1:0] pre;
  logic [RES_W-1:0] post;
  logic [INT_W-1:0] int_mag;

  always_comb begin
    pre = {{(RES_W-ACC_W){1'b0}}, acc_i};
`ifdef MUL_ROUND_EN
    post             = pre + ROUND_CONST;
    overflow_shift_o = ~(|pre[RES_W-1:OVF_LO]) & (|post[RES_W-1:OVF_LO]);
`else
    post             = pre;
    overflow_shift_o = 1'b0;
`endif
    overflow_high_o = |pre[RES_W-1:OVF_LO];
    result_o        = post;
    // A zero magnitude never reports a negative sign (covers -0 operands).
    sign_o          = sign_i & (|post);
    int_mag         = {1'b0, post[SEL_HI:INT_LO]};
    signed_result_o = sign_o ? (~int_mag + INT_W'(1)) : int_mag;
  end

endmodule

// File: rtl/seq_fixed_multiplier.sv
// Iterative sign-magnitude Q15.16 multiplier, one shift-add step per cycle.
// Fixed latency: start accepted at edge E0, done pulses after edge E32.
// Optional feature macro: MUL_ROUND_EN (see mul_flag_gen).
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   start          request, sampled only in IDLE
//   a, b           sign-magnitude Q15.16 operands
//   busy           high from the accepting edge until done is asserted
//   done           one-cycle pulse, outputs valid from this cycle
//   result         magnitude product {2'b0, |a|*|b|}
//   signedResult   signed integer part result[46:32]
//   sign           product sign, 0 for a zero result
//   overflowHigh   product bits above the selector window set
//   overflowShift  rounding pushed the product out of range
module seq_fixed_multiplier
  import fixed_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic [INT_W-1:0] signedResult,
  output logic             sign,
  output logic             overflowHigh,
  output logic             overflowShift
);

  state_e             state_q, state_d;
  logic [WIDTH-2:0]   mcand_q, mcand_d;
  logic [WIDTH-2:0]   mplier_q, mplier_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [INT_W-1:0]   sres_q, sres_d;
  logic               sign_q, sign_d;
  logic               ovh_q, ovh_d;
  logic               ovs_q, ovs_d;

  logic [RES_W-1:0]   fg_result;
  logic [INT_W-1:0]   fg_sres;
  logic               fg_sign;
  logic               fg_ovh;
  logic               fg_ovs;

  mul_flag_gen u_flag_gen (
    .acc_i            (acc_q),
    .sign_i           (neg_q),
    .result_o         (fg_result),
    .signed_result_o  (fg_sres),
    .sign_o           (fg_sign),
    .overflow_high_o  (fg_ovh),
    .overflow_shift_o (fg_ovs)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    sres_d   = sres_q;
    sign_d   = sign_q;
    ovh_d    = ovh_q;
    ovs_d    = ovs_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a[WIDTH-2:0];
          mplier_d = b[WIDTH-2:0];
          neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
          acc_d    = '0;
          cnt_d    = CNT_INIT;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // MSB-first shift-add over multiplier bits 30..0.
        acc_d = (acc_q << 1)
              + (mplier_q[cnt_q] ? {{(ACC_W-WIDTH+1){1'b0}}, mcand_q} : '0);
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FINISH: begin
        result_d = fg_result;
        sres_d   = fg_sres;
        sign_d   = fg_sign;
        ovh_d    = fg_ovh;
        ovs_d    = fg_ovs;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sres_q   <= '0;
      sign_q   <= 1'b0;
      ovh_q    <= 1'b0;
      ovs_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      sres_q   <= sres_d;
      sign_q   <= sign_d;
      ovh_q    <= ovh_d;
      ovs_q    <= ovs_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign signedResult  = sres_q;
  assign sign          = sign_q;
  assign overflowHigh  = ovh_q;
  assign overflowShift = ovs_q;

endmodule
